// File: rtl/reset_sequencer.sv
// Staged reset release: holds all downstream domains in reset, then releases them
// one at a time in index order, waiting for each ready acknowledgement plus a settle gap.

module reset_sequencer_lane (
  input  logic check_en,
  input  logic released,
  input  logic ready,
  input  logic waiting,
  output logic fault
);
  // The stage currently being waited on may legitimately still be low.
  assign fault = check_en & released & ~ready & ~waiting;
endmodule

module reset_sequencer #(
  parameter int N_STAGES       = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int FW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                soft_reset_req,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_reset,
  output logic                all_ready,
  output logic                busy,
  output logic                timeout_err,
  output logic                drop_err,
  output logic [FW-1:0]       failed_stage
);
  localparam int HG   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC = (HG > TIMEOUT_CYCLES) ? HG : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] K_LAST    = FW'(N_STAGES - 1);

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [FW-1:0]       k;
  logic [FW-1:0]       kn;
  logic                check_en;
  logic [N_STAGES-1:0] fault;
  logic [FW-1:0]       drop_idx;

  assign kn       = k + 1'b1;
  assign check_en = (state == S_WAIT) || (state == S_GAP) || (state == S_DONE);

  for (genvar j = 0; j < N_STAGES; j++) begin : g_lane
    reset_sequencer_lane u_lane (
      .check_en (check_en),
      .released (~stage_reset[j]),
      .ready    (stage_ready[j]),
      .waiting  ((state == S_WAIT) && (k == FW'(j))),
      .fault    (fault[j])
    );
  end

  // Lowest faulting stage wins.
  always_comb begin
    drop_idx = '0;
    for (int j = N_STAGES - 1; j >= 0; j--)
      if (fault[j]) drop_idx = FW'(j);
  end

  always_ff @(posedge clk) begin
    if (reset || soft_reset_req) begin
      state        <= S_HOLD;
      cnt          <= '0;
      k            <= '0;
      stage_reset  <= '1;
      all_ready    <= 1'b0;
      busy         <= 1'b1;
      timeout_err  <= 1'b0;
      drop_err     <= 1'b0;
      failed_stage <= '0;
    end else if (|fault) begin
      state        <= S_ERR;
      stage_reset  <= '1;
      all_ready    <= 1'b0;
      busy         <= 1'b0;
      drop_err     <= 1'b1;
      failed_stage <= drop_idx;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt            <= '0;
            state          <= S_WAIT;
            stage_reset[0] <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (stage_ready[k]) begin
            cnt <= '0;
            if (k == K_LAST) begin
              state     <= S_DONE;
              all_ready <= 1'b1;
              busy      <= 1'b0;
            end else if (GAP_CYCLES == 0) begin
              k               <= kn;
              stage_reset[kn] <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end else if (cnt == TO_LAST) begin
            state        <= S_ERR;
            stage_reset  <= '1;
            busy         <= 1'b0;
            timeout_err  <= 1'b1;
            failed_stage <= k;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt             <= '0;
            k               <= kn;
            state           <= S_WAIT;
            stage_reset[kn] <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
